// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch
//  Brief    : MIPS IF stage with one outstanding imem request, a one-entry
//             hold buffer and delay-slot-aware redirect handling.
//             Optional IF_ALIGN_CHECK_EN adds a sticky addr_error output.
//  Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
`ifdef IF_ALIGN_CHECK_EN
    output logic        addr_error,
`endif
    input  logic        stall,
    input  logic        jump_branch,
    input  logic        jump_target,
    input  logic        jump_reg,
    input  logic [31:0] jr_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic [31:0] pc_id,
    output logic [31:0] instr_id,
    output logic        instr_valid_id
);

    logic        r_outstanding;
    logic [31:0] r_req_pc;
    logic [31:0] r_last_req_pc;
    logic        r_hold_valid;
    logic [31:0] r_hold_instr;
    logic [31:0] r_hold_pc;
    logic        r_redir_pending;
    logic [31:0] r_redir_pc;
    logic [31:0] r_ds_pc;

    logic        w_accept;
    logic        w_advance;
    logic        w_capture;
    logic        w_issue;
    logic        w_redir_eligible;
    logic [31:0] w_pc_id_plus4;
    logic [31:0] w_branch_target;
    logic [31:0] w_target_raw;
    logic [31:0] w_target;
    logic [31:0] w_ds_pc;
    logic [31:0] w_redir_addr;

    // Responses with nothing in flight (e.g. issued before a reset) are dropped.
    assign w_accept  = imem_rvalid & r_outstanding;
    assign w_advance = ~stall | ~instr_valid_id;

    // Only one redirect may be tracked; the delay slot must come first anyway.
    assign w_capture = instr_valid_id & w_advance & ~r_redir_pending
                     & (jump_branch | jump_target | jump_reg);

    assign w_pc_id_plus4   = pc_id + 32'd4;
    assign w_branch_target = w_pc_id_plus4 + {{14{jr_pc[17]}}, jr_pc[17:0]};
    assign w_target_raw    = jump_reg    ? jr_pc :
                             jump_target ? {pc_id[31:28], instr_id[25:0], 2'b00} :
                                           w_branch_target;

`ifdef IF_ALIGN_CHECK_EN
    assign w_target = {w_target_raw[31:2], 2'b00};
`else
    assign w_target = w_target_raw;
`endif

    assign w_ds_pc          = w_capture ? w_pc_id_plus4 : r_ds_pc;
    assign w_redir_addr     = w_capture ? w_target : r_redir_pc;
    assign w_redir_eligible = (w_capture | r_redir_pending) & (r_last_req_pc == w_ds_pc);

    // A request is held back whenever its response could find both ID and
    // the hold buffer occupied; a draining hold buffer frees the slot.
    assign w_issue = ~rst & (~r_outstanding | w_accept)
                   & ~(~w_advance & (r_hold_valid | w_accept));

    assign imem_req  = w_issue;
    assign imem_addr = w_redir_eligible ? w_redir_addr : r_req_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding   <= 1'b0;
            r_req_pc        <= RESET_PC;
            r_last_req_pc   <= RESET_PC;
            r_hold_valid    <= 1'b0;
            r_hold_instr    <= 32'h0;
            r_hold_pc       <= RESET_PC;
            r_redir_pending <= 1'b0;
            r_redir_pc      <= RESET_PC;
            r_ds_pc         <= RESET_PC;
            pc_id           <= RESET_PC;
            instr_id        <= 32'h0;
            instr_valid_id  <= 1'b0;
        end else begin
            if (w_issue) begin
                r_outstanding <= 1'b1;
                r_last_req_pc <= imem_addr;
                r_req_pc      <= imem_addr + 32'd4;
            end else if (w_accept) begin
                r_outstanding <= 1'b0;
            end

            if (w_advance) begin
                if (r_hold_valid) begin
                    pc_id          <= r_hold_pc;
                    instr_id       <= r_hold_instr;
                    instr_valid_id <= 1'b1;
                    r_hold_valid   <= w_accept;
                    if (w_accept) begin
                        r_hold_instr <= imem_rdata;
                        r_hold_pc    <= r_last_req_pc;
                    end
                end else if (w_accept) begin
                    pc_id          <= r_last_req_pc;
                    instr_id       <= imem_rdata;
                    instr_valid_id <= 1'b1;
                end else begin
                    instr_id       <= 32'h0;
                    instr_valid_id <= 1'b0;
                end
            end else if (w_accept) begin
                r_hold_valid <= 1'b1;
                r_hold_instr <= imem_rdata;
                r_hold_pc    <= r_last_req_pc;
            end

            if (w_issue && w_redir_eligible) begin
                r_redir_pending <= 1'b0;
            end else if (w_capture) begin
                r_redir_pending <= 1'b1;
                r_redir_pc      <= w_target;
                r_ds_pc         <= w_pc_id_plus4;
            end
        end
    end

`ifdef IF_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_error <= 1'b0;
        end else if (w_capture && (w_target_raw[1:0] != 2'b00)) begin
            addr_error <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_fetch
//  Brief    : Directed self-checking bench for instruction_fetch.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        jump_branch;
    logic        jump_target;
    logic        jump_reg;
    logic [31:0] jr_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic [31:0] pc_id;
    logic [31:0] instr_id;
    logic        instr_valid_id;
`ifdef IF_ALIGN_CHECK_EN
    logic        addr_error;
`endif

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef IF_ALIGN_CHECK_EN
        .addr_error     (addr_error),
`endif
        .stall          (stall),
        .jump_branch    (jump_branch),
        .jump_target    (jump_target),
        .jump_reg       (jump_reg),
        .jr_pc          (jr_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_rvalid    (imem_rvalid),
        .pc_id          (pc_id),
        .instr_id       (instr_id),
        .instr_valid_id (instr_valid_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors;
    int          miscompares;
    int          lat;
    logic        mem_busy;
    logic [31:0] mem_addr;
    int          mem_cnt;
    logic        stray;
    logic        obs_req;
    logic [31:0] obs_addr;

    // Instruction memory contents: the J at 0x40, everything else tagged by address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h0800_0100;
        return 32'hC000_0000 | a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: present the memory response, sample the request at negedge,
    // then return just after the next rising edge.
    task automatic cycle();
        if (rst) mem_busy = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (stray) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
            stray       = 1'b0;
        end else if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_addr);
                mem_busy    = 1'b0;
            end
        end
        @(negedge clk);
        obs_req  = imem_req;
        obs_addr = imem_addr;
        if (imem_req) begin
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_cnt  = lat;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_id(input logic [31:0] pc);
        check("id_valid", instr_valid_id, 1'b1);
        check("id_pc", pc_id, pc);
        check("id_instr", instr_id, mem_word(pc));
    endtask

    task automatic expect_req(input logic [31:0] addr);
        check("req", obs_req, 1'b1);
        check("req_addr", obs_addr, addr);
    endtask

    // Steady single-cycle stream: request addr while ID shows addr-4.
    task automatic stream(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            cycle();
            expect_req(start + 32'(4 * i));
            expect_id(start + 32'(4 * i) - 32'd4);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; lat = 1;
        mem_busy = 1'b0; mem_addr = 32'h0; mem_cnt = 0; stray = 1'b0;
        rst = 1'b1; stall = 1'b0;
        jump_branch = 1'b0; jump_target = 1'b0; jump_reg = 1'b0; jr_pc = 32'h0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;

        cycle(); cycle();
        check("rst_req", obs_req, 1'b0);
        check("rst_valid", instr_valid_id, 1'b0);
        check("rst_instr", instr_id, 32'h0);
        check("rst_pc", pc_id, 32'h0);

        // Sequential fetch at one instruction per cycle
        rst = 1'b0;
        cycle();
        expect_req(32'h0);
        check("first_valid", instr_valid_id, 1'b0);
        stream(32'h4, 5);

        // Stall with 0x10 in ID; 0x14 parks in the hold buffer
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_noreq", obs_req, 1'b0);
            expect_id(32'h10);
        end
        stall = 1'b0;
        cycle();
        expect_req(32'h18);
        expect_id(32'h14);
        stream(32'h1C, 3);

        // Taken BEQ at 0x20, offset -8
        jump_branch = 1'b1; jr_pc = 32'h0003_FFF8;
        cycle();
        jump_branch = 1'b0; jr_pc = 32'h0;
        expect_req(32'h1C);
        expect_id(32'h24);
        stream(32'h20, 10);

        // J at 0x40 -> 0x400
        jump_target = 1'b1;
        cycle();
        jump_target = 1'b0;
        expect_req(32'h400);
        expect_id(32'h44);
        stream(32'h404, 1);

        // JR at 0x400 to reach 0x80
        jump_reg = 1'b1; jr_pc = 32'h7C;
        cycle();
        jump_reg = 1'b0; jr_pc = 32'h0;
        expect_req(32'h7C);
        expect_id(32'h404);
        stream(32'h80, 1);

        // Latency 3, JR at 0x80 -> 0x1000 waits behind the delay slot
        lat = 3;
        stream(32'h84, 1);
        jump_reg = 1'b1; jr_pc = 32'h1000;
        cycle();
        jump_reg = 1'b0; jr_pc = 32'h0;
        check("jr_c1_noreq", obs_req, 1'b0);
        check("jr_c1_bubble", instr_valid_id, 1'b0);
        check("jr_c1_pc", pc_id, 32'h80);
        cycle();
        check("jr_c2_noreq", obs_req, 1'b0);
        check("jr_c2_bubble", instr_valid_id, 1'b0);
        cycle();
        expect_req(32'h1000);
        expect_id(32'h84);
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("jr_wait_noreq", obs_req, 1'b0);
            check("jr_wait_bubble", instr_valid_id, 1'b0);
        end
        cycle();
        expect_req(32'h1004);
        expect_id(32'h1000);

        // Reset mid-flight, then a stray response
        rst = 1'b1;
        cycle();
        check("mrst_req", obs_req, 1'b0);
        check("mrst_valid", instr_valid_id, 1'b0);
        check("mrst_pc", pc_id, 32'h0);
        rst = 1'b0; stray = 1'b1;
        cycle();
        expect_req(32'h0);
        check("stray_valid", instr_valid_id, 1'b0);
        check("stray_instr", instr_id, 32'h0);
        check("stray_pc", pc_id, 32'h0);
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("restart_noreq", obs_req, 1'b0);
            check("restart_bubble", instr_valid_id, 1'b0);
        end
        cycle();
        expect_req(32'h4);
        expect_id(32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
